// File: rtl/joystick_poll_ctrl.sv
// rtl/joystick_poll_ctrl.sv - periodic 5-byte SPI poll of the analog joystick, X/Y/button extraction
module joystick_poll_ctrl #(
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss_n,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] buttons,
  output logic       sample_valid,
  output logic       busy
);

  // One phase counter serves every timed state, so it is sized for the longest phase.
  localparam int MAX_A = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int MAX_B = (CLK_DIV > POLL_PERIOD) ? CLK_DIV : POLL_PERIOD;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE,
    S_WAIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [2:0]      byte_cnt;
  logic [6:0]      tx_sr;    // bits still to send after the one on mosi
  logic [7:0]      rx_sr;
  logic [39:0]     rx_all;   // received bytes, byte 0 ends up in [39:32]
  logic [7:0]      tx0;

  // Command byte 0 carries the LED bits; MSB set marks it as a poll command.
  assign tx0 = {6'b100000, led};

  // Transaction sequencer: SPI timing, byte assembly and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rx_all       <= '0;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      ss_n         <= 1'b1;
      x_pos        <= 10'd512;
      y_pos        <= 10'd512;
      buttons      <= 3'b000;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_SETUP;
            ss_n     <= 1'b0;
            busy     <= 1'b1;
            mosi     <= tx0[7];
            tx_sr    <= tx0[6:0];
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!sclk) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                // Byte boundary: keep the byte and preload the all-zero follow-up byte.
                rx_all   <= {rx_all[31:0], rx_sr};
                byte_cnt <= byte_cnt + 1'b1;
                tx_sr    <= 7'd0;
                mosi     <= 1'b0;
                state    <= (byte_cnt == 3'd4) ? S_DONE : S_GAP;
              end else begin
                mosi  <= tx_sr[6];
                tx_sr <= {tx_sr[5:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          ss_n         <= 1'b1;
          mosi         <= 1'b0;
          x_pos        <= {rx_all[25:24], rx_all[39:32]};
          y_pos        <= {rx_all[9:8], rx_all[23:16]};
          buttons      <= rx_all[2:0];
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          cnt          <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == POLL_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joystick_poll_ctrl.sv
// tb/tb_joystick_poll_ctrl.sv - directed self-checking bench for joystick_poll_ctrl
module tb_joystick_poll_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int SS_SETUP    = 8;
  localparam int BYTE_GAP    = 6;
  localparam int POLL_PERIOD = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] led = 2'b00;
  logic       miso;
  logic       sclk, mosi, ss_n, sample_valid, busy;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;

  int checks = 0;
  int errors = 0;

  logic [39:0] rx_bits = '0;
  int          idx = 40;
  logic [39:0] mosi_cap = '0;
  int          sv_count = 0;
  int          hi_run = 0;
  int          last_hi = 0;

  joystick_poll_ctrl #(
    .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .led(led), .miso(miso),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .x_pos(x_pos), .y_pos(y_pos),
    .buttons(buttons), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Joystick slave model: mode 0, next bit presented after every sclk fall.
  assign miso = (idx < 40) ? rx_bits[39 - idx] : 1'b0;
  always @(negedge ss_n) begin
    idx      <= 0;
    mosi_cap <= '0;
  end
  always @(negedge sclk) if (ss_n === 1'b0) idx <= idx + 1;
  always @(posedge sclk) if (ss_n === 1'b0) mosi_cap <= {mosi_cap[38:0], mosi};

  // Pulse counter and ss_n-high run tracker.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) sv_count <= sv_count + 1;
    if (ss_n === 1'b1) hi_run <= hi_run + 1;
    else if (hi_run != 0) begin
      last_hi <= hi_run;
      hi_run  <= 0;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(output int low, output int rises, output int first,
                         output int maxlow, output int busy_bad);
    int   n;
    int   run;
    logic prev;
    bit   seen;
    low = 0; rises = 0; first = -1; maxlow = 0; busy_bad = 0;
    run = 0; prev = 1'b0; seen = 1'b0; n = 0;
    while (ss_n !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("ss_n_fall", {39'd0, ss_n}, 40'd0);
    n = 0;
    while (ss_n === 1'b0 && n < 1000) begin
      low++;
      if (busy !== 1'b1) busy_bad++;
      if (sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        if (first < 0) first = low - 1;
        if (seen && run > maxlow) maxlow = run;
        seen = 1'b1;
        run  = 0;
      end else if (sclk === 1'b0) begin
        run++;
      end
      prev = sclk;
      tick();
      n++;
    end
    check("ss_n_rise", {39'd0, ss_n}, 40'd1);
  endtask

  initial begin
    int low, rises, first, maxlow, busy_bad, sv0, n;

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("rst_ss_n", {39'd0, ss_n}, 40'd1);
    check("rst_sclk", {39'd0, sclk}, 40'd0);
    check("rst_mosi", {39'd0, mosi}, 40'd0);
    check("rst_x", {30'd0, x_pos}, 40'd512);
    check("rst_y", {30'd0, y_pos}, 40'd512);
    check("rst_buttons", {37'd0, buttons}, 40'd0);
    check("rst_valid", {39'd0, sample_valid}, 40'd0);
    check("rst_busy", {39'd0, busy}, 40'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_disabled_ss_n", {39'd0, ss_n}, 40'd1);

    // Single transaction with timing measurements.
    rx_bits = 40'h34_02_78_01_05;
    led     = 2'b01;
    enable  = 1'b1;
    sv0     = sv_count;
    run_txn(low, rises, first, maxlow, busy_bad);
    rx_bits = 40'h00_00_FF_03_00;
    repeat (3) tick();
    check("t1_mosi_byte0", {32'd0, mosi_cap[39:32]}, 40'h81);
    check("t1_mosi_bytes1_4", {8'd0, mosi_cap[31:0]}, 40'h0);
    check("t1_x", {30'd0, x_pos}, 40'd564);
    check("t1_y", {30'd0, y_pos}, 40'd376);
    check("t1_buttons", {37'd0, buttons}, 40'd5);
    check("t1_valid_pulses", 40'(sv_count - sv0), 40'd1);
    check("t1_ss_low_cycles", 40'(low), 40'(SS_SETUP + 40 * 2 * CLK_DIV + 4 * BYTE_GAP + 1));
    check("t1_sclk_rises", 40'(rises), 40'd40);
    check("t1_first_rise", 40'(first), 40'(SS_SETUP + CLK_DIV));
    check("t1_interbyte_low", 40'(maxlow), 40'(BYTE_GAP + CLK_DIV));
    check("t1_busy_during", 40'(busy_bad), 40'd0);
    check("t1_busy_after", {39'd0, busy}, 40'd0);

    // Back-to-back polling with enable held high.
    for (int k = 0; k < 2; k++) begin
      run_txn(low, rises, first, maxlow, busy_bad);
      check("poll_gap", {39'd0, (last_hi >= POLL_PERIOD && last_hi <= POLL_PERIOD + 2)}, 40'd1);
      repeat (2) tick();
      check("poll_x", {30'd0, x_pos}, 40'd0);
      check("poll_y", {30'd0, y_pos}, 40'd1023);
    end

    // Enable dropped during byte 2: transaction still completes once.
    rx_bits = 40'h10_01_20_02_03;
    n = 0;
    while (ss_n !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    sv0 = sv_count;
    repeat (100) tick();
    enable = 1'b0;
    n = 0;
    while (ss_n !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drop_valid_pulses", 40'(sv_count - sv0), 40'd1);
    check("drop_x", {30'd0, x_pos}, 40'd272);
    check("drop_y", {30'd0, y_pos}, 40'd544);
    check("drop_buttons", {37'd0, buttons}, 40'd3);
    low = 0;
    repeat (60) begin
      tick();
      if (ss_n !== 1'b1) low++;
    end
    check("drop_stays_idle", 40'(low), 40'd0);
    enable = 1'b1;
    n = 0;
    while (ss_n !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    check("reenable_start", {39'd0, (ss_n === 1'b0 && n <= 21)}, 40'd1);

    // Reset asserted mid-transfer, during byte 3.
    repeat (130) tick();
    #2 rst_n = 1'b0;
    sv0 = sv_count;
    #1;
    check("midrst_ss_n", {39'd0, ss_n}, 40'd1);
    check("midrst_sclk", {39'd0, sclk}, 40'd0);
    check("midrst_x", {30'd0, x_pos}, 40'd512);
    check("midrst_y", {30'd0, y_pos}, 40'd512);
    check("midrst_busy", {39'd0, busy}, 40'd0);
    repeat (3) tick();
    check("midrst_no_valid", 40'(sv_count - sv0), 40'd0);

    // Fresh transaction after reset release.
    rx_bits = 40'hAA_FD_55_FE_FF;
    led     = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    sv0   = sv_count;
    run_txn(low, rises, first, maxlow, busy_bad);
    repeat (3) tick();
    check("fresh_mosi_byte0", {32'd0, mosi_cap[39:32]}, 40'h82);
    check("fresh_x", {30'd0, x_pos}, 40'd426);
    check("fresh_y", {30'd0, y_pos}, 40'd597);
    check("fresh_buttons", {37'd0, buttons}, 40'd7);
    check("fresh_rises", 40'(rises), 40'd40);
    check("fresh_ss_low_cycles", 40'(low), 40'(SS_SETUP + 40 * 2 * CLK_DIV + 4 * BYTE_GAP + 1));
    check("fresh_valid_pulses", 40'(sv_count - sv0), 40'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
